// File: rtl/alu_sched.sv
// Time-shares one combinational ALU between two requesters with round-robin grant.
// Multi-bit SLL/SRL run as repeated 1-bit passes. Optional ALU_SCHED_STATS_EN adds completion counters.
module alu_sched #(
  parameter int WORD_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WORD_W-1:0] rsp0_result,
  output logic [2:0]        rsp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WORD_W-1:0] rsp1_result,
  output logic [2:0]        rsp1_flags,
  output logic [3:0]        alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_ovf,
  output logic              busy,
  output logic [1:0]        dbg_state
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]       done0_cnt,
  output logic [15:0]       done1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0]         ALU_SLL = 4'h0;
  localparam logic [3:0]         ALU_SRL = 4'h1;
  localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

  // Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
  // a response transfers where rspN_valid && rspN_ready. Requesters hold valid and
  // operands stable until accepted; the scheduler holds result/flags until consumed.

  state_t              state_q;
  logic                last_grant_q;
  logic                owner_q;
  logic [3:0]          op_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   b_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [WORD_W-1:0]   res_q;
  logic [2:0]          flags_q;

  logic                grant0, grant1;
  logic                acc0, acc1;
  logic [3:0]          sel_op;
  logic [WORD_W-1:0]   sel_a, sel_b;
  logic                sel_shift;
  logic                rsp_hs;

  // A tie goes to whichever requester was not granted last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = nRST && (state_q == IDLE) && grant0;
  assign req1_ready = nRST && (state_q == IDLE) && grant1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  assign sel_op    = acc1 ? req1_op : req0_op;
  assign sel_a     = acc1 ? req1_a  : req0_a;
  assign sel_b     = acc1 ? req1_b  : req0_b;
  assign sel_shift = (sel_op == ALU_SLL) || (sel_op == ALU_SRL);

  assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0 || acc1) begin
            op_q         <= sel_op;
            a_q          <= sel_a;
            b_q          <= sel_b;
            cnt_q        <= sel_b[SHAMT_W-1:0];
            owner_q      <= acc1;
            last_grant_q <= acc1;
            state_q      <= sel_shift ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_result;
          flags_q <= {alu_ovf, alu_neg, alu_zero};
          state_q <= RESP;
        end
        SHIFT: begin
          // a_q doubles as the shift accumulator, one ALU pass per cycle.
          if (cnt_q != '0) begin
            a_q   <= alu_result;
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            res_q   <= a_q;
            flags_q <= {1'b0, a_q[WORD_W-1], (a_q == '0)};
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op = 4'h0;
    alu_a  = '0;
    alu_b  = '0;
    if (state_q == EXEC) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end else if (state_q == SHIFT && cnt_q != '0) begin
      alu_op = op_q;
      alu_a  = a_q;
    end
  end

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_flags  = flags_q;
  assign rsp1_flags  = flags_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] done0_q, done1_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      done0_q <= '0;
      done1_q <= '0;
    end else if (rsp_hs) begin
      if (owner_q) done1_q <= done1_q + 16'd1;
      else         done0_q <= done0_q + 16'd1;
    end
  end

  assign done0_cnt = done0_q;
  assign done1_cnt = done1_q;
`endif

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares the single combinational ALU between two requesters (execute-stage and multi-cycle helper path).
- Uses round-robin arbitration and valid/ready handshakes on both request and response.
- Expands multi-bit SLL/SRL into repeated 1-bit ALU shift passes, because the ALU shifts by exactly one bit per operation.
- Registers every result and its flags before returning them to the owning requester.

Parameters:
- WORD_W, 32, datapath width; must match the ALU ports.
- SHAMT_W, 5, width of the shift amount taken from portB low bits.

Ports:
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an op pending
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  4  aluop_t from cpu_types_pkg
- req0_a, req0_b  in  WORD_W  operands
- rsp0_valid  out  1  result ready for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  WORD_W  result
- rsp0_flags  out  3  {ovf, neg, zero}
- req1_*, rsp1_*  same set as requester 0, for requester 1
- alu_op  out  4  to ALU aluop
- alu_a, alu_b  out  WORD_W  to ALU portA/portB
- alu_result  in  WORD_W  from ALU
- alu_zero, alu_neg, alu_ovf  in  1  from ALU flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous, active-low, on nRST, sampled at the CLK rising edge.
- Reset values: state=IDLE, last_grant=1 (so req0 wins the first tie), all ready/valid outputs 0, rsp results/flags 0, alu_op=4'h0, alu_a=alu_b=0, busy=0.
- Reset mid-operation: the in-flight op is abandoned and no response is issued.
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester that is not last_grant.
  - reqN_ready is high combinationally only for the granted requester.
  - On valid&&ready: capture op/a/b/owner, update last_grant.
  - Next state is SHIFT if op is ALU_SLL or ALU_SRL, else EXEC.
- EXEC (exactly 1 cycle):
  - alu_op/alu_a/alu_b = captured values.
  - At the edge, latch alu_result and {alu_ovf, alu_neg, alu_zero}, then go to RESP.
- SHIFT:
  - cnt loads b[SHAMT_W-1:0] at accept; acc loads a.
  - Each cycle with cnt!=0: alu_op = captured shift op, alu_a = acc, alu_b = 0; acc <= alu_result; cnt--.
  - When cnt==0: result = acc, flags = {0, acc[31], acc==0}, go to RESP.
  - shamt 0 therefore spends 1 cycle in SHIFT and returns a unchanged.
  - Upper bits of b above SHAMT_W are ignored.
- RESP:
  - rspN_valid is high for the owner only; result/flags are held stable.
  - Stays until rspN_ready=1, then goes to IDLE.
  - No new request is accepted in RESP, so back-to-back ops cost ≥1 IDLE cycle.
- ALU outputs are 0 / 4'h0 in IDLE and RESP.
- Latency from accept edge to rsp_valid:
  - Non-shift op: 2 edges.
  - Shift op: shamt+2 edges.
- Requester rules: reqN_valid and operands must stay stable until accepted. Dropping valid early is a protocol violation; the scheduler need not handle it.
- Simultaneous events:
  - A requester may re-assert valid during its own RESP; it is arbitrated on return to IDLE.
  - If both are valid with last_grant=0, req1 wins; the next tie goes to req0.

Optional Feature:
- ALU_SCHED_STATS_EN defined:
  - Adds outputs done0_cnt and done1_cnt, each 16 bits.
  - Each increments on its completed rsp handshake, wraps at 16'hFFFF->0, and resets to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then req0 ALU_ADD a=5 b=7 -> req0_ready in cycle 0, rsp0_valid 2 edges later, result=12, flags=000; hold rsp0_ready=0 for 3 cycles -> result stable.
- Both valid on the same cycle after reset (req0 ALU_SUB 3-5, req1 ALU_OR 0xF0|0x0F) -> req0 granted first: result 0xFFFFFFFE, neg=1. Then req1: result 0x000000FF.
- req1 ALU_SLL a=0x1 b=31 -> rsp1_valid after 33 edges, result=0x80000000, flags={0,1,0}; busy high throughout.
- req0 ALU_SRL a=0x80000000 b=0 -> result=0x80000000 after 2 edges; b=0x25 (shamt 5) -> 0x04000000.
- ADD 0x7FFFFFFF+1 -> ovf passed through from the ALU. Separately, assert nRST=0 mid-SHIFT -> next cycle IDLE, no rsp_valid ever issued for that op.
- Streams of 100 ops with both requesters continuously valid -> grants strictly alternate. With ALU_SCHED_STATS_EN: done0_cnt=done1_cnt=50.
